// File: rtl/ram_blk_pipe.sv
// ram_blk_pipe: single-clock simple dual-port table RAM with a 1- or 2-stage
// registered read pipeline, write-first forwarding on same-cycle address
// collisions, and an optional post-reset clear engine that zeroes every entry.
module ram_blk_pipe #(
  parameter int ADDR_BITS  = 5,
  parameter int DATA_BITS  = 193,
  parameter int RD_LATENCY = 2,
  parameter int INIT_CLEAR = 1
) (
  input  logic                 clk,
  input  logic                 aresetn,
  input  logic                 wr_en,
  input  logic [ADDR_BITS-1:0] wr_addr,
  input  logic [DATA_BITS-1:0] wr_data,
  input  logic                 rd_en,
  input  logic [ADDR_BITS-1:0] rd_addr,
  output logic [DATA_BITS-1:0] rd_data,
  output logic                 rd_valid,
  output logic                 init_busy
);

  localparam int DEPTH = 2 ** ADDR_BITS;

  typedef enum logic {
    CLEAR,
    READY
  } state_e;

  state_e                 state_q;
  logic [ADDR_BITS-1:0]   clr_cnt_q;
  logic                   init_busy_q;

  logic [DATA_BITS-1:0]   mem [DEPTH];

  logic                   mem_we_d;
  logic [ADDR_BITS-1:0]   mem_waddr_d;
  logic [DATA_BITS-1:0]   mem_wdata_d;

  logic                   rd_fire_d;
  logic [DATA_BITS-1:0]   rd_snap_d;

  logic                   rd_v1_q;
  logic [DATA_BITS-1:0]   rd_d1_q;

  // Clear engine: walk every address once after reset, then stay READY.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state_q     <= (INIT_CLEAR != 0) ? CLEAR : READY;
      clr_cnt_q   <= '0;
      init_busy_q <= (INIT_CLEAR != 0);
    end else begin
      case (state_q)
        CLEAR: begin
          clr_cnt_q <= clr_cnt_q + 1'b1;
          if (clr_cnt_q == '1) begin
            state_q     <= READY;
            init_busy_q <= 1'b0;
          end
        end
        default: begin
          state_q     <= READY;
          init_busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign init_busy = init_busy_q;

  // Array write port: clear engine owns it while busy; nothing is written
  // on an edge that arrives while reset is asserted.
  always_comb begin
    mem_we_d    = 1'b0;
    mem_waddr_d = wr_addr;
    mem_wdata_d = wr_data;
    if (state_q == CLEAR) begin
      mem_we_d    = aresetn;
      mem_waddr_d = clr_cnt_q;
      mem_wdata_d = '0;
    end else begin
      mem_we_d    = aresetn & wr_en;
    end
  end

  // Array storage; contents survive reset.
  always_ff @(posedge clk) begin
    if (mem_we_d) begin
      mem[mem_waddr_d] <= mem_wdata_d;
    end
  end

  // Read snapshot at the request edge, with write-first forwarding.
  always_comb begin
    rd_fire_d = (state_q == READY) & rd_en;
    rd_snap_d = mem[rd_addr];
    if (wr_en && (wr_addr == rd_addr)) begin
      rd_snap_d = wr_data;
    end
  end

  // First read stage: data only loads on a request so it holds otherwise.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      rd_v1_q <= 1'b0;
      rd_d1_q <= '0;
    end else begin
      rd_v1_q <= rd_fire_d;
      if (rd_fire_d) begin
        rd_d1_q <= rd_snap_d;
      end
    end
  end

  if (RD_LATENCY == 1) begin : g_lat1
    assign rd_valid = rd_v1_q;
    assign rd_data  = rd_d1_q;
  end else if (RD_LATENCY == 2) begin : g_lat2
    logic                 rd_v2_q;
    logic [DATA_BITS-1:0] rd_d2_q;

    // Second read stage: forwards the captured snapshot one cycle later.
    always_ff @(posedge clk or negedge aresetn) begin
      if (!aresetn) begin
        rd_v2_q <= 1'b0;
        rd_d2_q <= '0;
      end else begin
        rd_v2_q <= rd_v1_q;
        if (rd_v1_q) begin
          rd_d2_q <= rd_d1_q;
        end
      end
    end

    assign rd_valid = rd_v2_q;
    assign rd_data  = rd_d2_q;
  end else begin : g_bad_latency
    $error("ram_blk_pipe: RD_LATENCY must be 1 or 2");
    assign rd_valid = 1'b0;
    assign rd_data  = '0;
  end

endmodule

// File: tb/tb_ram_blk_pipe.sv
// tb_ram_blk_pipe: drives a latency-1 and a latency-2 instance with identical
// stimulus and compares both against a timestamped reference model.
module tb_ram_blk_pipe;

  localparam int AW    = 5;
  localparam int DW    = 193;
  localparam int DEPTH = 32;
  localparam int MAXC  = 4096;

  logic          clk = 1'b0;
  always #5 clk = ~clk;

  logic          aresetn;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data1, rd_data2;
  logic          rd_valid1, rd_valid2;
  logic          init_busy1, init_busy2;

  ram_blk_pipe #(.ADDR_BITS(AW), .DATA_BITS(DW), .RD_LATENCY(1), .INIT_CLEAR(1)) u_lat1 (
    .clk(clk), .aresetn(aresetn),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(rd_data1), .rd_valid(rd_valid1), .init_busy(init_busy1)
  );

  ram_blk_pipe #(.ADDR_BITS(AW), .DATA_BITS(DW), .RD_LATENCY(2), .INIT_CLEAR(1)) u_lat2 (
    .clk(clk), .aresetn(aresetn),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(rd_data2), .rd_valid(rd_valid2), .init_busy(init_busy2)
  );

  int            n_vec = 0;
  int            n_err = 0;

  // Reference model: table contents, and per-edge record of issued reads.
  logic [DW-1:0] m [DEPTH];
  bit            req_v [MAXC];
  logic [DW-1:0] req_d [MAXC];
  int            cyc = 0;
  int            epoch = 0;
  int            clr_left = 0;
  logic [DW-1:0] last1 = '0;
  logic [DW-1:0] last2 = '0;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [DW-1:0] rnd();
    logic [DW-1:0] v;
    v = '0;
    for (int k = 0; k < 7; k++) v = (v << 32) | DW'($urandom);
    return v;
  endfunction

  // One clock: model the edge, then check all outputs on the falling edge.
  task automatic tick();
    int e;
    bit v1, v2;
    @(posedge clk);
    e = cyc;
    if (clr_left > 0) begin
      clr_left--;
      req_v[e] = 1'b0;
      req_d[e] = '0;
      if (clr_left == 0) foreach (m[i]) m[i] = '0;
    end else begin
      req_v[e] = rd_en;
      req_d[e] = (wr_en && wr_addr == rd_addr) ? wr_data : m[rd_addr];
      if (wr_en) m[wr_addr] = wr_data;
    end
    @(negedge clk);
    v1 = (e >= epoch) && req_v[e];
    v2 = (e - 1 >= epoch) && req_v[e - 1];
    if (v1) last1 = req_d[e];
    if (v2) last2 = req_d[e - 1];
    chk("busy_l1",  DW'(init_busy1), DW'(clr_left > 0));
    chk("busy_l2",  DW'(init_busy2), DW'(clr_left > 0));
    chk("valid_l1", DW'(rd_valid1),  DW'(v1));
    chk("valid_l2", DW'(rd_valid2),  DW'(v2));
    chk("data_l1",  rd_data1, last1);
    chk("data_l2",  rd_data2, last2);
    cyc++;
    if (cyc >= MAXC) begin
      $display("FAIL cycle_budget obs=%0d exp<%0d", cyc, MAXC);
      $fatal(1, "cycle budget exhausted");
    end
  endtask

  task automatic step(input bit we, input int wa, input logic [DW-1:0] wd,
                      input bit re, input int ra);
    wr_en   = we;
    wr_addr = wa[AW-1:0];
    wr_data = wd;
    rd_en   = re;
    rd_addr = ra[AW-1:0];
    tick();
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 0, '0, 1'b0, 0);
  endtask

  // Assert reset mid-cycle, check the asynchronous values, release on a falling edge.
  task automatic do_reset(input int hold);
    #2 aresetn = 1'b0;
    #1;
    chk("rst_valid_l1", DW'(rd_valid1),  '0);
    chk("rst_valid_l2", DW'(rd_valid2),  '0);
    chk("rst_data_l1",  rd_data1,        '0);
    chk("rst_data_l2",  rd_data2,        '0);
    chk("rst_busy_l1",  DW'(init_busy1), DW'(1));
    chk("rst_busy_l2",  DW'(init_busy2), DW'(1));
    repeat (hold) @(posedge clk);
    @(negedge clk);
    aresetn  = 1'b1;
    epoch    = cyc;
    clr_left = DEPTH;
    last1    = '0;
    last2    = '0;
  endtask

  initial begin
    aresetn = 1'b1;
    wr_en   = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    rd_en   = 1'b1;
    rd_addr = '0;

    // Clear with rd_en held from release; write pulses to addr 5 must be ignored.
    do_reset(2);
    for (int i = 0; i < DEPTH; i++) step(i == 4 || i == 9, 5, DW'('hFF), 1'b1, 5);
    for (int i = 0; i < DEPTH; i++) step(1'b0, 0, '0, 1'b1, i);
    idle(3);

    // Reset at clear cycle 10 restarts the full clear.
    do_reset(1);
    idle(10);
    do_reset(2);
    idle(DEPTH + 2);

    // Latency check.
    step(1'b1, 7, DW'('h1A5), 1'b0, 0);
    idle(2);
    step(1'b0, 0, '0, 1'b1, 7);
    idle(3);

    // Collision forwarding.
    step(1'b1, 3, DW'('h11), 1'b0, 0);
    idle(1);
    step(1'b1, 3, DW'('h22), 1'b1, 3);
    step(1'b1, 3, DW'('h33), 1'b0, 0);
    idle(3);
    step(1'b0, 0, '0, 1'b1, 3);
    idle(3);

    // Streaming.
    for (int i = 0; i < DEPTH; i++) step(1'b1, i, DW'(i + 100), 1'b0, 0);
    for (int i = 0; i < DEPTH; i++) step(1'b0, 0, '0, 1'b1, DEPTH - 1 - i);
    idle(3);

    // Random traffic over a narrow address range to provoke collisions.
    repeat (400) step(1'($urandom_range(0, 1)), $urandom_range(0, 7), rnd(),
                      1'($urandom_range(0, 1)), $urandom_range(0, 7));
    idle(3);

    // Reset with reads in flight.
    step(1'b0, 0, '0, 1'b1, 1);
    step(1'b1, 2, rnd(), 1'b1, 2);
    do_reset(1);
    idle(DEPTH + 3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
